// File: rtl/tx_pkg.sv
// Shared definitions for the buffered transmit path: FSM encoding, SPI word
// layout and the 9-bit FIFO entry.
package tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    SEND  = 2'd2,
    DRAIN = 2'd3
  } tx_state_e;

  localparam int EOP_BIT   = 15;
  localparam int VALID_BIT = 14;
  localparam int BYTE_MSB  = 7;
  localparam int BYTE_LSB  = 0;

  typedef struct packed {
    logic       eop;
    logic [7:0] data;
  } tx_entry_t;

endpackage

// File: rtl/tx_byte_fifo.sv
// DEPTH x 9 show-ahead FIFO with occupancy counter and synchronous flush.
// Flush wins over write and read in the same cycle.
module tx_byte_fifo
  import tx_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            wr_en,
  input  tx_entry_t       wr_entry,
  input  logic            rd_en,
  output tx_entry_t       head,
  output logic [LW-1:0]   level,
  output logic [LW-1:0]   level_nxt,
  output logic            full,
  output logic            empty
);

  localparam int AW = $clog2(DEPTH);

  tx_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            do_wr, do_rd;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign do_wr = wr_en & ~full & ~flush;
  assign do_rd = rd_en & ~empty & ~flush;

  always_comb begin
    level_nxt = level;
    if (flush)
      level_nxt = '0;
    else if (do_wr && !do_rd)
      level_nxt = level + LW'(1);
    else if (do_rd && !do_wr)
      level_nxt = level - LW'(1);
  end

  // Pointers are exactly AW bits wide, so wrap modulo DEPTH comes for free.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      level <= level_nxt;
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_entry;
  end

  // Storage is never cleared; hide stale contents while empty.
  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/tx_buffered_top.sv
// Buffered transmit stage: SPI word intake, byte FIFO toward the framer,
// frame lifecycle FSM, jabber guard and sticky error flags.
module tx_buffered_top
  import tx_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int START_LEVEL  = 4,
  parameter int JABBER_LIMIT = 1000000,
  localparam int LW          = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   spi_data,
  input  logic          spi_data_strobe,
  output logic          spi_data_request,
  input  logic          go,
  input  logic          abort,
  output logic [7:0]    byte_data,
  output logic          byte_eop,
  output logic          byte_valid,
  input  logic          byte_take,
  output logic          txen,
  output logic [LW-1:0] level,
  output logic          overrun,
  output logic          underrun,
  output logic          jabber
);

  tx_state_e     state, state_nxt;
  logic          eop_seen, eop_nxt;
  logic          was_strobe;
  logic [31:0]   jab_cnt;
  logic          accept, eop_acc, jab_hit, do_abort;
  logic          fifo_full, fifo_empty, fifo_wr;
  logic [LW-1:0] level_nxt;
  tx_entry_t     wr_entry, head;
  logic          spi_unused;

  assign spi_unused = ^spi_data[13:8];

  // Rising edge of the level strobe; words arriving in IDLE are dropped.
  assign accept   = spi_data_strobe & ~was_strobe & (state != IDLE);
  assign eop_acc  = accept & spi_data[EOP_BIT];
  // Fires on the last of JABBER_LIMIT consecutive txen cycles.
  assign jab_hit  = txen & (jab_cnt == 32'(JABBER_LIMIT - 1));
  assign do_abort = abort | jab_hit;

  assign wr_entry.eop  = spi_data[EOP_BIT];
  assign wr_entry.data = spi_data[BYTE_MSB:BYTE_LSB];
  assign fifo_wr       = accept & spi_data[VALID_BIT] & ~do_abort;

  tx_byte_fifo #(.DEPTH(DEPTH), .LW(LW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (do_abort),
    .wr_en     (fifo_wr),
    .wr_entry  (wr_entry),
    .rd_en     (byte_take),
    .head      (head),
    .level     (level),
    .level_nxt (level_nxt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign byte_data  = head.data;
  assign byte_eop   = head.eop;
  assign byte_valid = ~fifo_empty;

  always_comb begin
    state_nxt = state;
    eop_nxt   = eop_seen;
    if (do_abort) begin
      state_nxt = IDLE;
      eop_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: if (go) begin
          state_nxt = FILL;
          eop_nxt   = 1'b0;
        end
        FILL: begin
          eop_nxt = eop_seen | eop_acc;
          if (level >= LW'(START_LEVEL) || eop_seen) state_nxt = SEND;
        end
        SEND: begin
          eop_nxt = eop_seen | eop_acc;
          if (eop_nxt) state_nxt = DRAIN;
        end
        DRAIN: begin
          eop_nxt = eop_seen | eop_acc;
          if (level == '0) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      eop_seen         <= 1'b0;
      was_strobe       <= 1'b0;
      txen             <= 1'b0;
      spi_data_request <= 1'b0;
      jab_cnt          <= '0;
      overrun          <= 1'b0;
      underrun         <= 1'b0;
      jabber           <= 1'b0;
    end else begin
      state      <= state_nxt;
      eop_seen   <= eop_nxt;
      was_strobe <= spi_data_strobe;
      txen       <= (state_nxt == SEND) || (state_nxt == DRAIN);
      // Request looks at next-cycle state so it tracks the new level at once.
      spi_data_request <= ((state_nxt == FILL) || (state_nxt == SEND)) && !eop_nxt &&
                          (level_nxt <= LW'(DEPTH - 2));
      jab_cnt    <= (txen && !do_abort) ? jab_cnt + 32'd1 : '0;

      if (state == IDLE && go && !do_abort) begin
        overrun  <= 1'b0;
        underrun <= 1'b0;
        jabber   <= 1'b0;
      end else begin
        if (accept && spi_data[VALID_BIT] && fifo_full && !do_abort) overrun <= 1'b1;
        if (state == SEND && byte_take && fifo_empty && !do_abort) underrun <= 1'b1;
        if (jab_hit) jabber <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tx_buffered_top.sv
// Directed bench for tx_buffered_top: expected bytes go into a scoreboard queue
// as words are issued; a monitor compares every byte the framer takes.
module tb_tx_buffered_top;

  localparam int DEPTH = 16;
  localparam int START = 4;
  localparam int JAB   = 100;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   spi_data;
  logic          spi_data_strobe, spi_data_request;
  logic          go, abort;
  logic [7:0]    byte_data;
  logic          byte_eop, byte_valid, byte_take, txen;
  logic [LW-1:0] level;
  logic          overrun, underrun, jabber;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_exp;

  tx_buffered_top #(.DEPTH(DEPTH), .START_LEVEL(START), .JABBER_LIMIT(JAB)) dut (
    .clk(clk), .reset(reset), .spi_data(spi_data), .spi_data_strobe(spi_data_strobe),
    .spi_data_request(spi_data_request), .go(go), .abort(abort),
    .byte_data(byte_data), .byte_eop(byte_eop), .byte_valid(byte_valid),
    .byte_take(byte_take), .txen(txen), .level(level),
    .overrun(overrun), .underrun(underrun), .jabber(jabber)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: mid-cycle, a take with valid head means a pop at the next edge.
  always @(negedge clk) begin
    if (!reset && byte_take && byte_valid) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected got %h expected none", {byte_eop, byte_data});
      end else begin
        mon_exp = exp_q.pop_front();
        if ({byte_eop, byte_data} !== mon_exp) begin
          n_fail++;
          $display("FAIL pop_data got %h expected %h", {byte_eop, byte_data}, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // One strobe edge; push=1 when the word should land in the FIFO.
  task automatic send_word(input logic [15:0] w, input bit push);
    spi_data = w;
    spi_data_strobe = 1'b1;
    if (push) exp_q.push_back({w[15], w[7:0]});
    tick();
    spi_data_strobe = 1'b0;
    tick();
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
  endtask

  task automatic pop_until_empty(output int n);
    n = 0;
    byte_take = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      n++;
      if (level == 0) break;
    end
    byte_take = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; spi_data = '0; spi_data_strobe = 1'b0;
    go = 1'b0; abort = 1'b0; byte_take = 1'b0;
    repeat (3) tick();
    chk("rst_outputs", {spi_data_request, byte_data, byte_eop, byte_valid, txen,
                        overrun, underrun, jabber}, 32'h0);
    chk("rst_level", level, 0);
    reset = 1'b0;
    tick();

    // Basic frame: start threshold, ordering, eop on the sixth byte.
    pulse_go();
    chk("go_request", spi_data_request, 1);
    send_word(16'h40A1, 1); send_word(16'h40B2, 1); send_word(16'h40C3, 1);
    chk("below_start_txen", txen, 0);
    chk("below_start_level", level, 3);
    spi_data = 16'h40D4; spi_data_strobe = 1'b1; exp_q.push_back(9'h0D4);
    tick();
    chk("fourth_level", level, 4);
    chk("fourth_txen_same", txen, 0);
    spi_data_strobe = 1'b0;
    tick();
    chk("fourth_txen_next", txen, 1);
    send_word(16'h40E5, 1); send_word(16'hC0F6, 1);
    chk("eop_request_low", spi_data_request, 0);
    pop_until_empty(n);
    chk("frame_pops", n, 6);
    chk("drain_txen_at_empty", txen, 1);
    tick();
    chk("idle_txen", txen, 0);

    // Fill to full, forced overrun, then read back unchanged.
    pulse_go();
    for (int i = 0; i < 14; i++) send_word(16'h4010 | 16'(i), 1);
    chk("req_at_14", spi_data_request, 1);
    send_word(16'h401E, 1);
    chk("req_drop_15", spi_data_request, 0);
    chk("level_15", level, 15);
    send_word(16'h401F, 1);
    chk("level_full", level, 16);
    send_word(16'h40FF, 0);
    chk("overrun_set", overrun, 1);
    chk("overrun_level", level, 16);
    pop_until_empty(n);
    chk("full_pops", n, 16);

    // Underrun: take with empty FIFO while in SEND.
    byte_take = 1'b1;
    tick();
    byte_take = 1'b0;
    chk("underrun_set", underrun, 1);
    chk("underrun_level", level, 0);
    pulse_abort();
    chk("abort_txen", txen, 0);

    // Abort mid-SEND with seven queued; IDLE ignores strobes.
    pulse_go();
    chk("go_clears_underrun", underrun, 0);
    chk("go_clears_overrun", overrun, 0);
    for (int i = 0; i < 7; i++) send_word(16'h4040 | 16'(i), 1);
    chk("pre_abort_level", level, 7);
    chk("pre_abort_txen", txen, 1);
    pulse_abort();
    chk("abort_level", level, 0);
    chk("abort_out", {txen, spi_data_request, byte_valid}, 0);
    send_word(16'h40AA, 0);
    chk("idle_strobe_ignored", level, 0);

    // Eop-only word during SEND with three bytes queued.
    pulse_go();
    for (int i = 0; i < 4; i++) send_word(16'h4031 + 16'(i), 1);
    byte_take = 1'b1;
    tick();
    byte_take = 1'b0;
    chk("eoponly_pre_level", level, 3);
    send_word(16'h8000, 0);
    chk("eoponly_request", spi_data_request, 0);
    chk("eoponly_level", level, 3);
    chk("eoponly_txen", txen, 1);
    pop_until_empty(n);
    chk("eoponly_pops", n, 3);
    tick();
    chk("eoponly_idle_txen", txen, 0);
    chk("eoponly_no_extra", byte_valid, 0);

    // Jabber: hold SEND without taking.
    pulse_go();
    for (int i = 0; i < 4; i++) send_word(16'h4050 + 16'(i), 1);
    n = 0;
    for (int k = 0; k < 300; k++) begin
      if (jabber) break;
      if (txen) n++;
      tick();
    end
    chk("jabber_set", jabber, 1);
    chk("jabber_txen_cycles", n, JAB);
    chk("jabber_flush", {txen, byte_valid}, 0);
    chk("jabber_level", level, 0);
    exp_q.delete();
    pulse_go();
    chk("go_clears_jabber", jabber, 0);
    pulse_abort();
    tick();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
